ct_spsram_8192x128_ctrl: RTL and testbench
==========================================

Name: ct_spsram_8192x128_ctrl

Overview:
- Sequencer and arbiter in front of one 8192x128 single-port SRAM (ct_spsram_8192x128). Owns all SRAM pins.
- After reset, optionally sweeps every entry to zero.
- Then shares the array between two requesters (port 0, port 1) using round-robin arbitration with valid/ready handshakes.
- Returns read data with fixed 1-cycle latency, tagged per port.

Parameters:
- ADDR_WIDTH, 13, SRAM address width (depth 8192).
- DATA_WIDTH, 128, data and bit-mask width.
- INIT_EN, 1, 1 = run zero-init sweep after reset; 0 = enter RUN directly.

Ports:
- forever_cpuclk  in  1  single clock; also feeds the SRAM CLK.
- cpurst  in  1  reset; synchronous, active-high.
- req0_vld  in  1  port 0 request valid.
- req0_rdy  out  1  port 0 request accepted this cycle when req0_vld & req0_rdy.
- req0_wr  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_WIDTH  entry index.
- req0_wdata  in  DATA_WIDTH  write data.
- req0_wmask  in  DATA_WIDTH  per-bit write enable, 1 = write bit.
- req1_vld, req1_rdy, req1_wr, req1_addr, req1_wdata, req1_wmask: same as port 0, for port 1.
- rsp0_vld  out  1  read data for port 0 valid on rsp_data.
- rsp1_vld  out  1  read data for port 1 valid on rsp_data.
- rsp_data  out  DATA_WIDTH  read data; equals sram_q.
- init_done  out  1  sweep complete; stays high until reset.
- sram_a  out  ADDR_WIDTH  SRAM A.
- sram_cen  out  1  SRAM CEN, active-low.
- sram_gwen  out  1  SRAM GWEN, active-low global write.
- sram_wen  out  DATA_WIDTH  SRAM WEN, active-low per bit.
- sram_d  out  DATA_WIDTH  SRAM D.
- sram_q  in  DATA_WIDTH  SRAM Q; valid 1 cycle after a read access.

Behaviour:
- Reset (cpurst=1 at a clock edge). State after the edge:
  - state = INIT if INIT_EN, else RUN.
  - init_cnt = 0; rr_ptr = port 0.
  - rsp0_vld = rsp1_vld = 0.
  - init_done = 0 if INIT_EN, else 1.
  - req0_rdy = req1_rdy = 0 while cpurst is high.
  - SRAM pins idle: sram_cen = 1, sram_gwen = 1, sram_wen all-ones, sram_a = 0, sram_d = 0.
- Reset mid-sweep restarts init_cnt at 0. Reset in RUN drops any pending response (no rsp_vld the following cycle).
- State INIT:
  - Each cycle drives sram_cen = 0, sram_gwen = 0, sram_wen = 0, sram_d = 0, sram_a = init_cnt; then init_cnt++.
  - The write with init_cnt = 8191 is the last. Next cycle: state = RUN, init_done = 1. Sweep takes exactly 8192 cycles.
  - init_cnt is 13 bits and never wraps past 8191.
  - req*_rdy = 0 throughout INIT.
- State RUN, arbitration (combinational, same cycle):
  - Only one valid: that port gets rdy = 1.
  - Both valid: the port named by rr_ptr gets rdy = 1; the other gets rdy = 0.
  - After any grant, rr_ptr moves to the non-granted port.
  - At most one rdy high per cycle. rdy never depends on the other port's rdy.
- Access (in the grant cycle):
  - SRAM pins are driven combinationally from the winner: sram_cen = 0, sram_a = addr.
  - Write: sram_gwen = 0, sram_wen = ~wmask, sram_d = wdata. A zero mask is still a legal accepted access.
  - Read: sram_gwen = 1, sram_wen all-ones, sram_d = 0.
  - No grant: SRAM pins idle as at reset.
- Response:
  - Read granted at cycle N → rspX_vld = 1 at N+1 for the granted port only, one cycle; rsp_data = sram_q.
  - Writes produce no response.
  - Back-to-back reads give a response every cycle.
  - Read-after-write to the same address on consecutive cycles returns the new data.
- Throughput: 1 access per cycle; no internal buffering. A requester holds vld and payload until rdy.

Test Plan:
- INIT_EN = 1; release reset; hold req0_vld = 1 → rdy = 0 for cycles 0..8191. sram_a counts 0..8191 with cen = gwen = 0 and wen = 0. init_done = 1 and req0_rdy = 1 at cycle 8192.
- After init, port 0 reads addr 0x1ABC → rsp0_vld = 1 next cycle, rsp_data = 0. Then write 0x1ABC = 128'hDEAD...BEEF with full mask, then read → returns DEAD...BEEF.
- Write addr 5 = all-ones, full mask. Then write addr 5 = 0 with wmask = 128'h00FF. Read addr 5 → 128'hFFFF...FF00; sram_wen on the second write = ~128'h00FF.
- Both ports valid continuously with reads for 6 cycles, rr_ptr = 0 at start → grants 0,1,0,1,0,1. rsp0/rsp1 alternate one cycle later; never both high.
- Assert cpurst at init_cnt = 4000 → next cycle init_cnt = 0, init_done = 0. The full 8192-cycle sweep repeats.
- Read granted at N with cpurst high at edge N+1 → rsp*_vld = 0 at N+1; SRAM pins idle.

Source files
------------

// File: rtl/ct_spsram_8192x128_ctrl.sv
// Sequencer and round-robin arbiter in front of a single-port 8192x128 SRAM.
// Runs an optional zero-fill sweep after reset, then serves two valid/ready requesters.
module ct_spsram_8192x128_ctrl #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned INIT_EN    = 1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  req0_vld,
  output logic                  req0_rdy,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [DATA_WIDTH-1:0] req0_wmask,
  input  logic                  req1_vld,
  output logic                  req1_rdy,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [DATA_WIDTH-1:0] req1_wmask,
  output logic                  rsp0_vld,
  output logic                  rsp1_vld,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic                    rr_ptr_q, rr_ptr_d;
  logic                    rsp0_q, rsp0_d;
  logic                    rsp1_q, rsp1_d;
  logic                    init_done_q, init_done_d;

  logic                    gnt0, gnt1;
  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [DATA_WIDTH-1:0]   sel_wmask;

  // rr_ptr names the port that wins a tie; grants are suppressed while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!cpurst && state_q == StRun) begin
      if (req0_vld && (!req1_vld || !rr_ptr_q)) begin
        gnt0 = 1'b1;
      end else if (req1_vld) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    sel_wr    = gnt1 ? req1_wr    : req0_wr;
    sel_addr  = gnt1 ? req1_addr  : req0_addr;
    sel_wdata = gnt1 ? req1_wdata : req0_wdata;
    sel_wmask = gnt1 ? req1_wmask : req0_wmask;
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    init_done_d = init_done_q;
    rsp0_d      = gnt0 & ~req0_wr;
    rsp1_d      = gnt1 & ~req1_wr;
    sram_cen    = 1'b1;
    sram_gwen   = 1'b1;
    sram_wen    = '1;
    sram_a      = '0;
    sram_d      = '0;
    if (!cpurst) begin
      unique case (state_q)
        StInit: begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = '0;
          sram_a    = init_cnt_q;
          if (init_cnt_q == LastAddr) begin
            state_d     = StRun;
            init_done_d = 1'b1;
          end else begin
            init_cnt_d = init_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (gnt0 || gnt1) begin
            sram_cen = 1'b0;
            sram_a   = sel_addr;
            if (sel_wr) begin
              sram_gwen = 1'b0;
              sram_wen  = ~sel_wmask;
              sram_d    = sel_wdata;
            end
            // Point at the loser so it wins the next tie.
            rr_ptr_d = gnt0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q     <= (INIT_EN != 0) ? StInit : StRun;
      init_cnt_q  <= '0;
      rr_ptr_q    <= 1'b0;
      rsp0_q      <= 1'b0;
      rsp1_q      <= 1'b0;
      init_done_q <= (INIT_EN == 0);
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp0_q      <= rsp0_d;
      rsp1_q      <= rsp1_d;
      init_done_q <= init_done_d;
    end
  end

  assign req0_rdy  = gnt0;
  assign req1_rdy  = gnt1;
  // A reset arriving the cycle after a read grant must hide that response.
  assign rsp0_vld  = rsp0_q & ~cpurst;
  assign rsp1_vld  = rsp1_q & ~cpurst;
  assign rsp_data  = sram_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_ct_spsram_8192x128_ctrl.sv
// Randomized bench for ct_spsram_8192x128_ctrl against an array-level memory model
// with a behavioural SRAM attached to the controller's pins.
module tb_ct_spsram_8192x128_ctrl;

  localparam int AW = 13;
  localparam int DW = 128;
  localparam int Depth = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_vld, req0_wr, req1_vld, req1_wr;
  logic          req0_rdy, req1_rdy;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req0_wmask, req1_wdata, req1_wmask;
  logic          rsp0_vld, rsp1_vld, init_done;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] sram_a;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d;
  logic [DW-1:0] sram_q = '0;

  ct_spsram_8192x128_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .req0_vld       (req0_vld),
    .req0_rdy       (req0_rdy),
    .req0_wr        (req0_wr),
    .req0_addr      (req0_addr),
    .req0_wdata     (req0_wdata),
    .req0_wmask     (req0_wmask),
    .req1_vld       (req1_vld),
    .req1_rdy       (req1_rdy),
    .req1_wr        (req1_wr),
    .req1_addr      (req1_addr),
    .req1_wdata     (req1_wdata),
    .req1_wmask     (req1_wmask),
    .rsp0_vld       (rsp0_vld),
    .rsp1_vld       (rsp1_vld),
    .rsp_data       (rsp_data),
    .init_done      (init_done),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  initial forever #5 clk = ~clk;

  // Behavioural SRAM; seeded with garbage so the zero sweep matters.
  logic [DW-1:0] sram_mem [Depth];
  logic          seed_mem = 1'b0;
  always @(posedge clk) begin
    if (seed_mem) begin
      for (int i = 0; i < Depth; i++) sram_mem[i] <= {$urandom, $urandom, $urandom, $urandom};
    end else if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= sram_mem[sram_a];
    end
  end

  // Reference model: expected array contents, tie-break favourite, outstanding response.
  logic [DW-1:0] exp_mem [Depth];
  int            favor;
  int            pend;
  logic [DW-1:0] pend_data;
  logic          obs_rsp0, obs_rsp1;
  logic [DW-1:0] obs_data, obs_wen;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cen"},  128'(sram_cen), 128'(1));
    chk({tag, "_gwen"}, 128'(sram_gwen), 128'(1));
    chk({tag, "_wen"},  sram_wen, '1);
    chk({tag, "_a"},    128'(sram_a), '0);
    chk({tag, "_d"},    sram_d, '0);
  endtask

  task automatic model_start();
    for (int i = 0; i < Depth; i++) exp_mem[i] = '0;
    favor = 0;
    pend  = -1;
  endtask

  task automatic rst_cycle();
    @(negedge clk);
    chk("rst_rdy0", 128'(req0_rdy), '0);
    chk("rst_rdy1", 128'(req1_rdy), '0);
    chk("rst_rsp0", 128'(rsp0_vld), '0);
    chk("rst_rsp1", 128'(rsp1_vld), '0);
    chk_idle("rst");
    @(posedge clk);
    pend = -1;
    #1;
  endtask

  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("init_a", 128'(sram_a), 128'(i));
      chk("init_cen", 128'(sram_cen), '0);
      chk("init_gwen", 128'(sram_gwen), '0);
      chk("init_wen", sram_wen, '0);
      chk("init_d", sram_d, '0);
      chk("init_rdy0", 128'(req0_rdy), '0);
      chk("init_rdy1", 128'(req1_rdy), '0);
      chk("init_done_lo", 128'(init_done), '0);
      @(posedge clk);
      #1;
    end
  endtask

  // One RUN-mode cycle: predict the winner and pins from the current requests.
  task automatic cycle(output int won);
    int            w;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, mask;
    @(negedge clk);
    if (req0_vld && req1_vld) w = favor;
    else if (req0_vld)        w = 0;
    else if (req1_vld)        w = 1;
    else                      w = -1;
    wr    = (w == 1) ? req1_wr    : req0_wr;
    addr  = (w == 1) ? req1_addr  : req0_addr;
    wdata = (w == 1) ? req1_wdata : req0_wdata;
    mask  = (w == 1) ? req1_wmask : req0_wmask;
    obs_rsp0 = rsp0_vld;
    obs_rsp1 = rsp1_vld;
    obs_data = rsp_data;
    obs_wen  = sram_wen;
    chk("rdy0", 128'(req0_rdy), 128'(w == 0));
    chk("rdy1", 128'(req1_rdy), 128'(w == 1));
    chk("rsp0", 128'(rsp0_vld), 128'(pend == 0));
    chk("rsp1", 128'(rsp1_vld), 128'(pend == 1));
    chk("rsp_excl", 128'(rsp0_vld & rsp1_vld), '0);
    if (pend >= 0) chk("rsp_data", rsp_data, pend_data);
    chk("init_done_hi", 128'(init_done), 128'(1));
    if (w < 0) begin
      chk_idle("idle");
    end else begin
      chk("acc_cen", 128'(sram_cen), '0);
      chk("acc_a", 128'(sram_a), 128'(addr));
      chk("acc_gwen", 128'(sram_gwen), 128'(!wr));
      chk("acc_wen", sram_wen, wr ? ~mask : '1);
      chk("acc_d", sram_d, wr ? wdata : '0);
    end
    @(posedge clk);
    pend = -1;
    if (w >= 0) begin
      if (wr) begin
        exp_mem[addr] = (exp_mem[addr] & ~mask) | (wdata & mask);
      end else begin
        pend      = w;
        pend_data = exp_mem[addr];
      end
      favor = 1 - w;
    end
    #1;
    won = w;
  endtask

  function automatic logic [DW-1:0] pick_mask();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      default: return {$urandom, $urandom, $urandom, $urandom};
    endcase
  endfunction

  task automatic random_phase(input int n);
    int won;
    for (int i = 0; i < n; i++) begin
      if (!req0_vld && $urandom_range(0, 3) != 0) begin
        req0_vld   = 1'b1;
        req0_wr    = 1'($urandom_range(0, 1));
        req0_addr  = AW'($urandom_range(0, 31));
        req0_wdata = {$urandom, $urandom, $urandom, $urandom};
        req0_wmask = pick_mask();
      end
      if (!req1_vld && $urandom_range(0, 3) != 0) begin
        req1_vld   = 1'b1;
        req1_wr    = 1'($urandom_range(0, 1));
        req1_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
        req1_wdata = {$urandom, $urandom, $urandom, $urandom};
        req1_wmask = pick_mask();
      end
      cycle(won);
      if (won == 0) req0_vld = 1'b0;
      if (won == 1) req1_vld = 1'b0;
    end
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    cycle(won);
  endtask

  task automatic drive0(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] mask);
    req0_vld   = 1'b1;
    req0_wr    = wr;
    req0_addr  = addr;
    req0_wdata = wdata;
    req0_wmask = mask;
  endtask

  initial begin
    int            won;
    logic [DW-1:0] beef;
    beef = 128'hDEADBEEF_0123_4567_89AB_CDEF_DEADBEEF;
    rst = 1'b1;
    req0_vld = 1'b0; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
    req1_vld = 1'b0; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
    pend = -1;
    favor = 0;
    seed_mem = 1'b1;
    @(posedge clk);
    #1;
    seed_mem = 1'b0;

    // Reset with a pending read on port 0; it must not be accepted until the sweep ends.
    drive0(1'b0, 13'h1ABC, '0, '0);
    rst_cycle();
    rst_cycle();
    rst = 1'b0;
    sweep(Depth);
    model_start();

    cycle(won);
    chk("first_grant", 128'(won), '0);
    req0_vld = 1'b0;
    cycle(won);
    chk("rd_1abc_vld", 128'(obs_rsp0), 128'(1));
    chk("rd_1abc_zero", obs_data, '0);

    // Write then immediately read back the same entry.
    drive0(1'b1, 13'h1ABC, beef, '1);
    cycle(won);
    drive0(1'b0, 13'h1ABC, '0, '0);
    cycle(won);
    req0_vld = 1'b0;
    cycle(won);
    chk("raw_data", obs_data, beef);

    // Partial-mask write over all-ones.
    drive0(1'b1, 13'd5, '1, '1);
    cycle(won);
    drive0(1'b1, 13'd5, '0, 128'h00FF);
    cycle(won);
    chk("mask_wen", obs_wen, ~128'h00FF);
    drive0(1'b1, 13'd5, '0, '0);
    cycle(won);
    chk("zero_mask_grant", 128'(won), '0);
    drive0(1'b0, 13'd5, '0, '0);
    cycle(won);
    req0_vld = 1'b0;
    cycle(won);
    chk("mask_data", obs_data, {{120{1'b1}}, 8'h00});

    // A lone port-1 grant leaves port 0 favoured for the alternation check.
    req1_vld = 1'b1; req1_wr = 1'b0; req1_addr = 13'h1ABC;
    cycle(won);
    chk("p1_grant", 128'(won), 128'(1));
    req0_vld = 1'b1; req0_wr = 1'b0; req0_addr = 13'd5;
    for (int i = 0; i < 6; i++) begin
      cycle(won);
      chk("rr_grant", 128'(won), 128'(i % 2));
      if (won == 0) req0_addr = req0_addr + 1'b1;
      else          req1_addr = req1_addr + 1'b1;
    end
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    cycle(won);

    random_phase(3000);

    // Read granted, then reset the next cycle: the response must vanish.
    req1_vld = 1'b1; req1_wr = 1'b0; req1_addr = 13'h1ABC;
    cycle(won);
    chk("drop_grant", 128'(won), 128'(1));
    req1_vld = 1'b0;
    req0_vld = 1'b1;
    rst = 1'b1;
    rst_cycle();
    rst = 1'b0;
    sweep(4000);
    rst = 1'b1;
    rst_cycle();
    rst = 1'b0;
    sweep(Depth);
    model_start();
    req0_vld = 1'b0;
    cycle(won);
    random_phase(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
